// File: rtl/conv_window_feeder_if.sv
// Bundle of command, SRAM-read and MAC-side signals for one conv_window_feeder.
// The master modport is the feeder's view; the slave modport is the view of
// whatever surrounds it (controller, SRAMs, quadrant tile).
interface conv_window_feeder_if #(
    parameter int unsigned ADDR_W = 10
);
    // Window request
    logic              start;
    logic [ADDR_W-1:0] i_base;
    logic [ADDR_W-1:0] row_stride;
    logic [ADDR_W-1:0] w_base;
    logic              busy;

    // SRAM read ports; data returns one cycle after ren/addr
    logic              i_ren;
    logic              w_ren;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       i_data;
    logic [15:0]       w_data;

    // MAC tile side
    logic [15:0]       mac_a;
    logic [15:0]       mac_b;
    logic              mac_clear;
    logic [15:0]       mac_out;

    // Window result
    logic [15:0]       result;
    logic              result_valid;

    modport master (
        input  start, i_base, row_stride, w_base,
        input  i_data, w_data, mac_out,
        output busy, i_ren, w_ren, i_addr, w_addr,
        output mac_a, mac_b, mac_clear, result, result_valid
    );

    modport slave (
        output start, i_base, row_stride, w_base,
        output i_data, w_data, mac_out,
        input  busy, i_ren, w_ren, i_addr, w_addr,
        input  mac_a, mac_b, mac_clear, result, result_valid
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Kernel-window sequencer for one quadrant MAC tile. Walks KH x KW terms over
// the input and weight SRAMs, streams one activation/weight pair per cycle to
// the MAC with clear on the first term, then captures the tile output.
module conv_window_feeder #(
    parameter int unsigned KW     = 3,
    parameter int unsigned KH     = 3,
    parameter int unsigned ADDR_W = 10
) (
    input logic                  clock,
    input logic                  reset,
    conv_window_feeder_if.master bus
);
    localparam int unsigned N     = KW * KH;
    localparam int unsigned KBITS = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CBITS = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [KBITS-1:0] KLast = KBITS'(N - 1);
    localparam logic [CBITS-1:0] CLast = CBITS'(KW - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWait,
        StCapture
    } state_e;

    state_e            state_q, state_d;
    logic [KBITS-1:0]  k_q, k_d;                  // term index of the read being issued
    logic [CBITS-1:0]  c_q, c_d;                  // column within current kernel row
    logic [ADDR_W-1:0] row_base_q, row_base_d;    // i_base + r * row_stride
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic              term_valid_q;              // read data on i_data/w_data this cycle
    logic              term_first_q;              // ... and it is term 0
    logic [15:0]       result_q;
    logic              result_valid_q;
    logic              issue;

    assign issue = (state_q == StRun);

    // Next-state logic: window FSM plus incremental row/column address walk
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        c_d        = c_q;
        row_base_d = row_base_q;
        stride_d   = stride_q;
        w_base_d   = w_base_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StRun;
                    k_d        = '0;
                    c_d        = '0;
                    row_base_d = bus.i_base;
                    stride_d   = bus.row_stride;
                    w_base_d   = bus.w_base;
                end
            end
            StRun: begin
                if (k_q == KLast) begin
                    state_d = StWait;
                end
                k_d = k_q + KBITS'(1);
                // Stepping the row base by stride avoids a multiplier.
                if (c_q == CLast) begin
                    c_d        = '0;
                    row_base_d = row_base_q + stride_q;
                end else begin
                    c_d = c_q + CBITS'(1);
                end
            end
            StWait: begin
                state_d = StCapture;
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: reads only in RUN; MAC inputs forced to zero between terms so
    // the free-running accumulator holds its value.
    always_comb begin
        bus.busy         = (state_q != StIdle);
        bus.i_ren        = issue;
        bus.w_ren        = issue;
        bus.i_addr       = '0;
        bus.w_addr       = '0;
        if (issue) begin
            bus.i_addr = row_base_q + ADDR_W'(c_q);
            bus.w_addr = w_base_q + ADDR_W'(k_q);
        end
        bus.mac_a        = term_valid_q ? bus.i_data : 16'h0000;
        bus.mac_b        = term_valid_q ? bus.w_data : 16'h0000;
        bus.mac_clear    = term_first_q;
        bus.result       = result_q;
        bus.result_valid = result_valid_q;
    end

    // State register; reset aborts any window without a result pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            k_q            <= '0;
            c_q            <= '0;
            row_base_q     <= '0;
            stride_q       <= '0;
            w_base_q       <= '0;
            term_valid_q   <= 1'b0;
            term_first_q   <= 1'b0;
            result_q       <= 16'h0000;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            c_q            <= c_d;
            row_base_q     <= row_base_d;
            stride_q       <= stride_d;
            w_base_q       <= w_base_d;
            term_valid_q   <= issue;
            term_first_q   <= issue && (k_q == '0);
            result_valid_q <= (state_q == StCapture);
            if (state_q == StCapture) begin
                result_q <= bus.mac_out;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with a behavioural SRAM and quadrant
// MAC model around it.
module tb_conv_window_feeder;
    typedef logic [9:0] addr9_t [9];

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [15:0] act_val;
    logic [15:0] wgt_val;

    conv_window_feeder_if #(.ADDR_W(10)) bus ();

    conv_window_feeder #(
        .KW    (3),
        .KH    (3),
        .ADDR_W(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAMs: every location holds the current pattern value, 1-cycle read latency
    always @(posedge clock) begin
        bus.i_data <= bus.i_ren ? act_val : 16'h0000;
        bus.w_data <= bus.w_ren ? wgt_val : 16'h0000;
    end

    // Quadrant model: signed MAC every clock, clear loads the product
    logic signed [31:0] acc = '0;
    wire  signed [31:0] prod = $signed(bus.mac_a) * $signed(bus.mac_b);
    always @(posedge clock) begin
        acc <= bus.mac_clear ? prod : acc + prod;
    end
    assign bus.mac_out = acc[31] ? 16'h0000 : acc[31:16];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a window in the current cycle (S) and checks S+1..S+12; returns in S+12.
    task automatic run_window(input string tag, input logic [9:0] ib, input logic [9:0] st,
                              input logic [9:0] wb, input logic [15:0] av,
                              input logic [15:0] wv, input addr9_t ei, input addr9_t ew,
                              input logic [15:0] eres, input bit extra_start);
        act_val        = av;
        wgt_val        = wv;
        bus.i_base     = ib;
        bus.row_stride = st;
        bus.w_base     = wb;
        bus.start      = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 1) bus.start = 1'b0;
            if (extra_start && t == 4) bus.start = 1'b1;
            if (extra_start && t == 5) bus.start = 1'b0;
            chk($sformatf("%s t=%0d busy", tag, t), {31'd0, bus.busy}, {31'd0, t <= 11});
            chk($sformatf("%s t=%0d result_valid", tag, t), {31'd0, bus.result_valid},
                {31'd0, t == 12});
            chk($sformatf("%s t=%0d mac_clear", tag, t), {31'd0, bus.mac_clear},
                {31'd0, t == 2});
            if (t <= 9) begin
                chk($sformatf("%s t=%0d i_addr", tag, t), {22'd0, bus.i_addr}, {22'd0, ei[t-1]});
                chk($sformatf("%s t=%0d w_addr", tag, t), {22'd0, bus.w_addr}, {22'd0, ew[t-1]});
                chk($sformatf("%s t=%0d ren", tag, t), {30'd0, bus.i_ren, bus.w_ren}, 32'd3);
            end
            if (t == 2) begin
                chk($sformatf("%s mac_a term0", tag), {16'd0, bus.mac_a}, {16'd0, av});
                chk($sformatf("%s mac_b term0", tag), {16'd0, bus.mac_b}, {16'd0, wv});
            end
            if (t == 11) begin
                chk($sformatf("%s mac_a idle", tag), {16'd0, bus.mac_a}, 32'd0);
            end
            if (t == 12) begin
                chk($sformatf("%s result", tag), {16'd0, bus.result}, {16'd0, eres});
            end
        end
    endtask

    addr9_t a_basic = '{10'd0, 10'd1, 10'd2, 10'd8, 10'd9, 10'd10, 10'd16, 10'd17, 10'd18};
    addr9_t w_basic = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8};
    addr9_t a_walk  = '{10'd5, 10'd6, 10'd7, 10'd13, 10'd14, 10'd15, 10'd21, 10'd22, 10'd23};
    addr9_t w_walk  = '{10'd100, 10'd101, 10'd102, 10'd103, 10'd104, 10'd105, 10'd106,
                        10'd107, 10'd108};
    addr9_t a_wrap  = '{10'd1022, 10'd1023, 10'd0, 10'd6, 10'd7, 10'd8, 10'd14, 10'd15, 10'd16};
    addr9_t w_wrap  = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3,
                        10'd4};

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        act_val        = 16'h0000;
        wgt_val        = 16'h0000;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.i_base     = '0;
        bus.row_stride = '0;
        bus.w_base     = '0;
        step();
        step();
        step();

        // Reset state
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst ren", {30'd0, bus.i_ren, bus.w_ren}, 32'd0);
        chk("rst i_addr", {22'd0, bus.i_addr}, 32'd0);
        chk("rst w_addr", {22'd0, bus.w_addr}, 32'd0);
        chk("rst mac_ab", {bus.mac_a, bus.mac_b}, 32'd0);
        chk("rst mac_clear", {31'd0, bus.mac_clear}, 32'd0);
        chk("rst result", {16'd0, bus.result}, 32'd0);
        chk("rst result_valid", {31'd0, bus.result_valid}, 32'd0);
        reset = 1'b0;
        step();

        // Basic, then a back-to-back window started in the result_valid cycle
        run_window("basic", 10'd0, 10'd8, 10'd0, 16'h0100, 16'h0100, a_basic, w_basic,
                   16'h0009, 1'b0);
        run_window("b2b", 10'd0, 10'd8, 10'd0, 16'h0100, 16'h0200, a_basic, w_basic,
                   16'h0012, 1'b0);
        step();

        run_window("walk", 10'd5, 10'd8, 10'd100, 16'h0100, 16'h0100, a_walk, w_walk,
                   16'h0009, 1'b0);
        step();
        run_window("wrap", 10'd1022, 10'd8, 10'd1020, 16'h0100, 16'h0100, a_wrap, w_wrap,
                   16'h0009, 1'b0);
        step();

        // Negative sum clamps to zero; start at S+4 must not spawn a second window
        run_window("neg", 10'd0, 10'd8, 10'd0, 16'h0100, 16'hFF00, a_basic, w_basic,
                   16'h0000, 1'b1);
        for (int t = 13; t <= 26; t++) begin
            step();
            chk($sformatf("neg idle t=%0d busy", t), {31'd0, bus.busy}, 32'd0);
            chk($sformatf("neg idle t=%0d result_valid", t), {31'd0, bus.result_valid}, 32'd0);
        end

        // Reset mid-RUN at S+4
        act_val        = 16'h0100;
        wgt_val        = 16'h0100;
        bus.i_base     = 10'd0;
        bus.row_stride = 10'd8;
        bus.w_base     = 10'd0;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort ren", {30'd0, bus.i_ren, bus.w_ren}, 32'd0);
        chk("abort addr", {12'd0, bus.i_addr, bus.w_addr}, 32'd0);
        chk("abort mac_ab", {bus.mac_a, bus.mac_b}, 32'd0);
        chk("abort result", {16'd0, bus.result}, 32'd0);
        for (int t = 0; t < 12; t++) begin
            step();
            chk($sformatf("abort t=%0d result_valid", t), {31'd0, bus.result_valid}, 32'd0);
        end

        run_window("fresh", 10'd0, 10'd8, 10'd0, 16'h0100, 16'h0100, a_basic, w_basic,
                   16'h0009, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
